fetch_inst_queue: RTL and testbench
===================================

// Module: fetch_inst_queue
// PURPOSE
// - Decoupling FIFO between the instruction fetch stage and the decode stage.
// - Captures each fetched word together with its PC, delay-slot flag and fetch exception flags.
// - Back-pressures fetch through in_ready, which fetch uses as its stall input.
// - Presents entries in order to decode, which consumes them with a valid/ready handshake.
// - A pipeline flush (exception or redirect) discards every entry.
// PARAMETERS
// - DEPTH   4              number of entries; power of two, >= 2
// - PTR_W   $clog2(DEPTH)  pointer width; derived, do not override
// PORTS
// - clk             in   1      rising-edge clock
// - resetn          in   1      asynchronous active-low reset
// - flush           in   1      synchronous; drop all entries and clear the fence
// - in_valid        in   1      fetch word valid this cycle (fetch !bubble)
// - in_ready        out  1      queue accepts a push this cycle
// - in_pc           in   32     PC of the fetched word
// - in_inst         in   32     fetched instruction word
// - in_delay_slot   in   1      word is a branch delay slot
// - in_adel         in   1      fetch address error
// - in_tlb_miss     in   1      fetch TLB refill
// - in_tlb_invalid  in   1      fetch TLB invalid
// - out_valid       out  1      head entry valid
// - out_ready       in   1      decode consumes the head this cycle
// - out_pc, out_inst, out_delay_slot, out_adel, out_tlb_miss, out_tlb_invalid
//                   out  32/32/1/1/1/1   head entry fields
// - occupancy       out  PTR_W+1   number of valid entries
// BEHAVIOUR
// - Reset (resetn=0, async): pointers 0, occupancy 0, fence 0.
//   - out_valid=0, in_ready=1.
//   - All out_* data fields 0.
// - push = in_valid & in_ready; pop = out_valid & out_ready. Both sampled at posedge clk.
// - in_ready = (occupancy < DEPTH) & !fence & !flush.
//   - Derived from registered state and flush only; never from out_ready (no pass-through when full).
// - out_valid = (occupancy != 0).
//   - out_* show the head entry; all out_* data fields are forced to 0 when out_valid=0.
// - Latency: a word pushed at edge N appears on out_* after edge N (earliest pop at edge N+1).
//   - There is no combinational in->out bypass.
// - Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
// - Full (occupancy=DEPTH): in_ready=0; a pop that cycle frees one slot for the next cycle.
// - Empty: out_valid=0; out_ready is ignored.
// - Pointers are PTR_W bits and wrap modulo DEPTH. occupancy is a separate PTR_W+1-bit counter.
// - Fence:
//   - Set when a pushed entry has any of adel, tlb_miss or tlb_invalid set.
//   - While set, in_ready=0, so nothing is fetched past a faulting word.
//   - The faulting entry itself is queued and drains normally.
//   - Cleared only by flush or reset.
// - Flush has priority over push and pop in the same cycle.
//   - Next cycle: occupancy 0, pointers 0, fence 0, out_valid 0.
//   - in_valid is ignored in the flush cycle.
// - Reset asserted mid-operation discards all state immediately (asynchronously).
// - Delay-slot and exception flags are stored per entry and are never merged or altered.
// - Only entries are stored; the queue performs no decoding.
// TESTING
// - Back-to-back flow, DEPTH=4: push PCs 0xBFC00000, 0xBFC00004, 0xBFC00008 with out_ready=1.
//   - out_pc follows one cycle behind each push.
//   - occupancy never exceeds 1.
// - Fill: out_ready=0, push 4 words.
//   - After the 4th edge, occupancy=4 and in_ready=0.
//   - A 5th in_valid is not stored.
//   - Then out_ready=1 pops the 4 words in order.
// - Wrap: 10 pushes and pops at random ratios, tracked against a scoreboard.
//   - PC/inst order is preserved across pointer wrap.
//   - occupancy always equals pushes minus pops.
// - Fence: push 0x80000000, then 0x80000004 with in_tlb_miss=1.
//   - in_ready=0 from the next cycle.
//   - Both entries drain, the second with out_tlb_miss=1.
//   - flush restores in_ready=1.
// - Flush with 3 entries plus a same-cycle push.
//   - Next cycle: occupancy=0 and out_valid=0; the pushed word is absent.
// - Async reset mid-stream: drop resetn between clock edges with 2 entries queued.
//   - out_valid=0 and occupancy=0 without waiting for a clock edge.
//   - in_ready=1 after resetn is released.

Source files
------------

// File: rtl/fetch_inst_queue_if.sv
// Fetch-to-decode queue handshake bundle: fetch push side, decode pop side and occupancy.
// The queue connects through the slave modport and the fetch/decode logic through the master modport.
interface fetch_inst_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             in_delay_slot;
  logic             in_adel;
  logic             in_tlb_miss;
  logic             in_tlb_invalid;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_delay_slot;
  logic             out_adel;
  logic             out_tlb_miss;
  logic             out_tlb_invalid;

  logic [PTR_W:0]   occupancy;

  modport slave (
    input  in_valid, in_pc, in_inst, in_delay_slot, in_adel, in_tlb_miss, in_tlb_invalid,
    output in_ready,
    output out_valid, out_pc, out_inst, out_delay_slot, out_adel, out_tlb_miss, out_tlb_invalid,
    input  out_ready,
    output occupancy
  );

  modport master (
    output in_valid, in_pc, in_inst, in_delay_slot, in_adel, in_tlb_miss, in_tlb_invalid,
    input  in_ready,
    input  out_valid, out_pc, out_inst, out_delay_slot, out_adel, out_tlb_miss, out_tlb_invalid,
    output out_ready,
    input  occupancy
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// Instruction queue decoupling fetch from decode. Stores PC, word, delay-slot and fetch
// exception flags per entry; a faulting push fences further fetch until flush or reset.
module fetch_inst_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  fetch_inst_queue_if.slave   q
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        delay_slot;
    logic        adel;
    logic        tlb_miss;
    logic        tlb_invalid;
  } entry_t;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

  function automatic logic has_fault(input entry_t e);
    return e.adel | e.tlb_miss | e.tlb_invalid;
  endfunction

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             fence_q, fence_d;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  entry_t           in_entry_s;
  entry_t           head_s;

  // Handshake qualification; in_ready never looks at out_ready, so a full queue never passes through.
  always_comb begin
    in_ready_s  = (occ_q < DEPTH_C) & ~fence_q & ~flush;
    out_valid_s = (occ_q != {(PTR_W+1){1'b0}});
    push_s      = q.in_valid & in_ready_s;
    pop_s       = out_valid_s & q.out_ready;
    in_entry_s  = '{pc:          q.in_pc,
                    inst:        q.in_inst,
                    delay_slot:  q.in_delay_slot,
                    adel:        q.in_adel,
                    tlb_miss:    q.in_tlb_miss,
                    tlb_invalid: q.in_tlb_invalid};
  end

  // Next-state for pointers, occupancy and fence; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    fence_d  = fence_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      occ_d    = {(PTR_W+1){1'b0}};
      fence_d  = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
      fence_d = fence_q | (push_s & has_fault(in_entry_s));
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {(PTR_W+1){1'b0}};
      fence_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      fence_q  <= fence_d;
    end
  end

  // Entry storage; contents are only visible while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_entry_s;
    end
  end

  // Head presentation, zeroed when empty so decode never sees stale data.
  always_comb begin
    if (out_valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
  end

  assign q.in_ready        = in_ready_s;
  assign q.out_valid       = out_valid_s;
  assign q.out_pc          = head_s.pc;
  assign q.out_inst        = head_s.inst;
  assign q.out_delay_slot  = head_s.delay_slot;
  assign q.out_adel        = head_s.adel;
  assign q.out_tlb_miss    = head_s.tlb_miss;
  assign q.out_tlb_invalid = head_s.tlb_invalid;
  assign q.occupancy       = occ_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Self-checking bench for fetch_inst_queue against a queue-based reference model.
module tb_fetch_inst_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ds;
    logic        adel;
    logic        tm;
    logic        ti;
  } ent_t;

  logic clk;
  logic resetn;
  logic flush;
  int   checks;
  int   errors;

  ent_t mq[$];
  bit   mfence;

  fetch_inst_queue_if #(.DEPTH(DEPTH)) q ();

  fetch_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_in_ready();
    return (mq.size() < DEPTH) && !mfence && !flush;
  endfunction

  function automatic ent_t m_head();
    ent_t z;
    z = '{pc: 32'h0, inst: 32'h0, ds: 1'b0, adel: 1'b0, tm: 1'b0, ti: 1'b0};
    if (mq.size() != 0) z = mq[0];
    return z;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ds, input logic adel, input logic tm, input logic ti);
    q.in_valid       = v;
    q.in_pc          = pc;
    q.in_inst        = inst;
    q.in_delay_slot  = ds;
    q.in_adel        = adel;
    q.in_tlb_miss    = tm;
    q.in_tlb_invalid = ti;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push = q.in_valid && m_in_ready();
    pop  = (mq.size() != 0) && q.out_ready;
    e = '{pc: q.in_pc, inst: q.in_inst, ds: q.in_delay_slot,
          adel: q.in_adel, tm: q.in_tlb_miss, ti: q.in_tlb_invalid};
    @(posedge clk);
    if (flush) begin
      mq.delete();
      mfence = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        if (e.adel || e.tm || e.ti) mfence = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (q.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", q.out_valid); end
    checks++;
    if (q.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", q.in_ready); end
    checks++;
    if (q.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", q.occupancy); end
    checks++;
    if ({q.out_pc, q.out_inst} !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h_%h want 0", q.out_pc, q.out_inst); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    q.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'hBFC0_0000 + 32'(4 * i);
      drive(1'b1, pc, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (q.out_valid !== 1'b1 || q.out_pc !== pc) begin
        errors++; $display("FAIL b2b_out_pc[%0d] got v=%b pc=%h want v=1 pc=%h", i, q.out_valid, q.out_pc, pc);
      end
      checks++;
      if (q.occupancy !== 3'd1 || q.out_inst !== m_head().inst) begin
        errors++; $display("FAIL b2b_occ_inst[%0d] got occ=%0d inst=%h want occ=1 inst=%h", i, q.occupancy, q.out_inst, m_head().inst);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (q.occupancy !== 3'd0 || q.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got occ=%0d v=%b want 0/0", q.occupancy, q.out_valid);
    end
  endtask

  task automatic test_fill();
    logic [31:0] pcs [4];
    q.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pcs[i] = 32'h0040_0000 + 32'(16 * i);
      drive(1'b1, pcs[i], $urandom, 1'(i & 1), 1'b0, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (q.occupancy !== 3'd4 || q.in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full got occ=%0d in_ready=%b want 4/0", q.occupancy, q.in_ready);
    end
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q.occupancy !== 3'd4) begin errors++; $display("FAIL fill_fifth got occ=%0d want 4", q.occupancy); end
    q.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q.out_pc !== pcs[i] || q.out_delay_slot !== 1'(i & 1) || q.out_inst !== m_head().inst) begin
        errors++; $display("FAIL fill_pop[%0d] got pc=%h ds=%b inst=%h want pc=%h ds=%b inst=%h",
                            i, q.out_pc, q.out_delay_slot, q.out_inst, pcs[i], 1'(i & 1), m_head().inst);
      end
      tick();
    end
    checks++;
    if (q.out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got v=%b want 0", q.out_valid); end
    q.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int   pushes = 0;
    int   pops   = 0;
    int   cyc    = 0;
    bit   done   = 0;
    ent_t h;
    while (!done && cyc < 400) begin
      drive((pushes < 10) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      q.out_ready = 1'($urandom_range(0, 1));
      checks++;
      if (q.in_ready !== m_in_ready()) begin
        errors++; $display("FAIL wrap_in_ready cyc %0d got %b want %b", cyc, q.in_ready, m_in_ready());
      end
      if (q.in_valid && m_in_ready()) pushes++;
      if (mq.size() != 0 && q.out_ready) pops++;
      tick();
      h = m_head();
      checks++;
      if (q.occupancy !== 3'(pushes - pops) || q.occupancy !== 3'(mq.size())) begin
        errors++; $display("FAIL wrap_occ cyc %0d got %0d want %0d", cyc, q.occupancy, pushes - pops);
      end
      checks++;
      if (q.out_valid !== (mq.size() != 0) || q.out_pc !== h.pc || q.out_inst !== h.inst ||
          q.out_delay_slot !== h.ds) begin
        errors++; $display("FAIL wrap_head cyc %0d got v=%b pc=%h inst=%h ds=%b want pc=%h inst=%h ds=%b",
                            cyc, q.out_valid, q.out_pc, q.out_inst, q.out_delay_slot, h.pc, h.inst, h.ds);
      end
      cyc++;
      done = (pushes >= 10) && (mq.size() == 0);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL wrap_timeout pushes=%0d pops=%0d want 10/10", pushes, pops); end
    q.out_ready = 1'b0;
  endtask

  task automatic test_fence();
    q.out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'h2402_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h8000_0004, 32'h2402_0002, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h8000_0008, 32'h2402_0003, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q.in_ready !== 1'b0) begin errors++; $display("FAIL fence_in_ready got %b want 0", q.in_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q.occupancy !== 3'd2) begin errors++; $display("FAIL fence_occ got %0d want 2", q.occupancy); end
    q.out_ready = 1'b1;
    checks++;
    if (q.out_pc !== 32'h8000_0000 || q.out_tlb_miss !== 1'b0) begin
      errors++; $display("FAIL fence_head0 got pc=%h tm=%b want 80000000/0", q.out_pc, q.out_tlb_miss);
    end
    tick();
    checks++;
    if (q.out_pc !== 32'h8000_0004 || q.out_tlb_miss !== 1'b1 || q.out_adel !== 1'b0 || q.out_tlb_invalid !== 1'b0) begin
      errors++; $display("FAIL fence_head1 got pc=%h tm=%b adel=%b ti=%b want 80000004/1/0/0",
                          q.out_pc, q.out_tlb_miss, q.out_adel, q.out_tlb_invalid);
    end
    tick();
    checks++;
    if (q.out_valid !== 1'b0 || q.in_ready !== 1'b0) begin
      errors++; $display("FAIL fence_drained got v=%b in_ready=%b want 0/0", q.out_valid, q.in_ready);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (q.in_ready !== 1'b1) begin errors++; $display("FAIL fence_flush_clear got %b want 1", q.in_ready); end
    q.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    q.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    flush = 1'b1;
    q.out_ready = 1'b1;
    drive(1'b1, 32'hCAFE_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (q.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", q.in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q.occupancy !== 3'd0 || q.out_valid !== 1'b0 || q.out_pc !== 32'h0) begin
      errors++; $display("FAIL flush_empty got occ=%0d v=%b pc=%h want 0/0/0", q.occupancy, q.out_valid, q.out_pc);
    end
    q.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    q.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q.occupancy !== 3'd2) begin errors++; $display("FAIL areset_pre got occ=%0d want 2", q.occupancy); end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (q.out_valid !== 1'b0 || q.occupancy !== 3'd0) begin
      errors++; $display("FAIL areset_immediate got v=%b occ=%0d want 0/0", q.out_valid, q.occupancy);
    end
    mq.delete();
    mfence = 1'b0;
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (q.in_ready !== 1'b1 || q.out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_release got in_ready=%b v=%b want 1/0", q.in_ready, q.out_valid);
    end
    drive(1'b1, 32'h2000_0100, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (q.out_pc !== 32'h2000_0100 || q.out_delay_slot !== 1'b1 || q.occupancy !== 3'd1) begin
      errors++; $display("FAIL areset_resume got pc=%h ds=%b occ=%0d want 20000100/1/1",
                          q.out_pc, q.out_delay_slot, q.occupancy);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    mfence      = 1'b0;
    resetn      = 1'b0;
    flush       = 1'b0;
    q.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    test_reset();
    #10;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    test_back_to_back();
    test_fill();
    test_wrap();
    test_fence();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
